// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel clock-enable generator.
// Each channel emits a one-cycle tick every D enabled cycles and a square
// wave sq with a period of 2*D cycles. D = max(act, 1) is programmable at
// runtime. New ratios are double-buffered so they only take effect at a
// period boundary.
// Optional feature: define CLK_DIV_SYNC_EN to add the sync port, which
// phase-aligns all channels.
module clk_div_gen #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*CNT_W-1:0] div,
`ifdef CLK_DIV_SYNC_EN
    input  logic                      sync,
`endif
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       sq,
    output logic [CHANNELS-1:0]       pending
);

    localparam logic [CNT_W-1:0] DEF_RATIO = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt [CHANNELS];
    logic [CNT_W-1:0] act [CHANNELS];
    logic [CNT_W-1:0] shd [CHANNELS];
    logic [CNT_W-1:0] lim [CHANNELS];
    logic [CHANNELS-1:0] wrap;

    // Terminal count is D-1; a ratio of 0 is clamped to 1, so its limit is 0.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            lim[k]  = (act[k] == '0) ? '0 : act[k] - CNT_W'(1);
            wrap[k] = en && (cnt[k] == lim[k]);
        end
    end

    // Per-channel counter, ratio double-buffer and registered outputs.
    always_ff @(posedge clk) begin
        for (int k = 0; k < CHANNELS; k++) begin
            if (!rst) begin
                cnt[k]     <= '0;
                act[k]     <= DEF_RATIO;
                shd[k]     <= DEF_RATIO;
                tick[k]    <= 1'b0;
                sq[k]      <= 1'b0;
                pending[k] <= 1'b0;
            end
`ifdef CLK_DIV_SYNC_EN
            else if (sync) begin
                // A load arriving with sync is dropped on purpose.
                cnt[k]  <= '0;
                tick[k] <= 1'b0;
                sq[k]   <= 1'b0;
                if (pending[k]) begin
                    act[k]     <= shd[k];
                    pending[k] <= 1'b0;
                end
            end
`endif
            else if (wrap[k]) begin
                cnt[k]     <= '0;
                tick[k]    <= 1'b1;
                sq[k]      <= ~sq[k];
                pending[k] <= 1'b0;
                if (load[k]) begin
                    // Load coinciding with the boundary governs the next period directly.
                    act[k] <= div[k*CNT_W +: CNT_W];
                    shd[k] <= div[k*CNT_W +: CNT_W];
                end else begin
                    act[k] <= shd[k];
                end
            end
            else begin
                tick[k] <= 1'b0;
                if (en) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
                if (load[k]) begin
                    shd[k]     <= div[k*CNT_W +: CNT_W];
                    pending[k] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

    localparam int CH  = 2;
    localparam int CW  = 16;
    localparam int DEF = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b1;
    logic [CH-1:0]   load = '0;
    logic [CH*CW-1:0] div = '0;
    logic            sync_v = 1'b0;
    logic [CH-1:0]   tick, sq, pending;

    int checks = 0;
    int errors = 0;
    int c = 0;

    always #5 clk = ~clk;

    clk_div_gen #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div     (div),
`ifdef CLK_DIV_SYNC_EN
        .sync    (sync_v),
`endif
        .tick    (tick),
        .sq      (sq),
        .pending (pending)
    );

    task automatic chk(input string nm, input logic [CH-1:0] act_v, input logic [CH-1:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s at c=%0d: got %b expected %b", nm, c, act_v, exp_v);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        c++;
    endtask

    function automatic int clamp1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Model: each channel tracks how many enabled cycles remain until its next tick.
    int  rem [CH];
    int  per [CH];
    int  nxr [CH];
    logic [CH-1:0] te, se, pe;

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < CH; k++) begin
                int dv;
                dv = int'(div[k*CW +: CW]);
                if (!rst) begin
                    per[k] = clamp1(DEF);
                    rem[k] = per[k];
                    nxr[k] = -1;
                    te[k]  = 1'b0;
                    se[k]  = 1'b0;
                end else if (sync_v) begin
                    if (nxr[k] >= 0) begin
                        per[k] = clamp1(nxr[k]);
                        nxr[k] = -1;
                    end
                    rem[k] = per[k];
                    te[k]  = 1'b0;
                    se[k]  = 1'b0;
                end else if (en) begin
                    rem[k] = rem[k] - 1;
                    if (rem[k] == 0) begin
                        te[k] = 1'b1;
                        se[k] = ~se[k];
                        if (load[k])
                            per[k] = clamp1(dv);
                        else if (nxr[k] >= 0)
                            per[k] = clamp1(nxr[k]);
                        rem[k] = per[k];
                        nxr[k] = -1;
                    end else begin
                        te[k] = 1'b0;
                        if (load[k]) nxr[k] = dv;
                    end
                end else begin
                    te[k] = 1'b0;
                    if (load[k]) nxr[k] = dv;
                end
                pe[k] = (nxr[k] >= 0);
            end
            #1;
            chk("model_tick", tick, te);
            chk("model_sq", sq, se);
            chk("model_pending", pending, pe);
        end
    end

    logic prev_sq1;

    initial begin
        // Reset held for two edges.
        nxt(); nxt();
        chk("reset_tick", tick, 2'b00);
        chk("reset_sq", sq, 2'b00);
        chk("reset_pending", pending, 2'b00);

        // Default ratio 2: ticks on even cycles, sq 0,1,1,0,0,1.
        rst = 1'b1;
        c = 0;
        for (int i = 1; i <= 6; i++) begin
            logic [5:0] sq_pat;
            sq_pat = 6'b100110;
            nxt();
            chk("def_tick", tick, (c % 2 == 0) ? 2'b11 : 2'b00);
            chk("def_sq0", {1'b0, sq[0]}, {1'b0, sq_pat[c-1]});
        end

        // ch0 ratio 5 loaded at cnt=0.
        load = 2'b01;
        div  = {16'd0, 16'd5};
        nxt();
        load = '0;
        chk("ld5_pend_rise", {1'b0, pending[0]}, 2'b01);
        chk("ld5_tick_c7", tick, 2'b00);
        nxt();
        chk("ld5_pend_fall", {1'b0, pending[0]}, 2'b00);
        chk("ld5_tick_c8", tick, 2'b11);
        while (c < 12) nxt();
        chk("ld5_tick_c12", tick, 2'b10);
        nxt();
        chk("ld5_tick_c13", {1'b0, tick[0]}, 2'b01);
        while (c < 18) nxt();
        chk("ld5_tick_c18", tick, 2'b11);
        nxt();

        // ch1 ratio 0 loaded on its wrap cycle (c=19 -> edge 20 wraps).
        load = 2'b10;
        div  = 32'h0000_0000;
        nxt();
        load = '0;
        chk("d1_tick_c20", {tick[1], 1'b0}, 2'b10);
        chk("d1_pend_c20", {pending[1], 1'b0}, 2'b00);
        prev_sq1 = sq[1];
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("d1_tick", {tick[1], 1'b0}, 2'b10);
            chk("d1_pend", {pending[1], 1'b0}, 2'b00);
            chk("d1_sq_toggle", {sq[1], 1'b0}, {~prev_sq1, 1'b0});
            prev_sq1 = sq[1];
        end

        // Pending load on ch0 then a one-cycle reset discards it.
        load = 2'b01;
        div  = {16'd0, 16'd7};
        nxt();
        load = '0;
        chk("rst_pend_before", {1'b0, pending[0]}, 2'b01);
        rst = 1'b0;
        nxt();
        chk("rst_mid_tick", tick, 2'b00);
        chk("rst_mid_sq", sq, 2'b00);
        chk("rst_mid_pending", pending, 2'b00);

        // Release with a ch0 load of 4; both channels tick 2 cycles later.
        rst  = 1'b1;
        load = 2'b01;
        div  = {16'd0, 16'd4};
        c = 0;
        nxt();
        load = '0;
        chk("rel_tick_c1", tick, 2'b00);
        chk("rel_pend_c1", pending, 2'b01);
        nxt();
        chk("rel_tick_c2", tick, 2'b11);
        chk("rel_pend_c2", pending, 2'b00);
        nxt();
        // ch0 at cnt=1 with D=4: three disabled cycles stretch the period to 7.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("hold_tick", tick, 2'b00);
            chk("hold_sq", sq, 2'b11);
        end
        en = 1'b1;
        nxt();
        chk("str_tick_c7", tick, 2'b10);
        nxt();
        chk("str_tick_c8", {1'b0, tick[0]}, 2'b00);
        nxt();
        chk("str_tick_c9", {1'b0, tick[0]}, 2'b01);
        while (c < 13) nxt();
        chk("str_tick_c13", {1'b0, tick[0]}, 2'b01);

`ifdef CLK_DIV_SYNC_EN
        // ch0 D=3, ch1 D=6, arbitrary phase, then sync with a dropped ch0 load.
        load = 2'b11;
        div  = {16'd6, 16'd3};
        nxt();
        load = '0;
        repeat (17) nxt();
        sync_v = 1'b1;
        load   = 2'b01;
        div    = {16'd6, 16'd9};
        nxt();
        sync_v = 1'b0;
        load   = '0;
        c = 0;
        chk("sync_sq", sq, 2'b00);
        chk("sync_tick", tick, 2'b00);
        chk("sync_pend", pending, 2'b00);
        for (int i = 1; i <= 12; i++) begin
            nxt();
            chk("sync_align", tick, {(c % 6 == 0), (c % 3 == 0)});
        end
`endif

        repeat (3) nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
